// File: rtl/lcd_pkg.sv
// Shared types, init command bytes and helper functions for the 4-bit HD44780 LCD driver.
package lcd_pkg;

    // Top-level sequencer states: power-on wait, four single-nibble wake-up writes, byte path, idle.
    typedef enum logic [3:0] {
        ST_BOOT,
        ST_POWERON,
        ST_INIT1,
        ST_INIT2,
        ST_INIT3,
        ST_INIT4,
        ST_HI,
        ST_LO,
        ST_IDLE
    } drv_state_t;

    // Phases of a single nibble strobe on the LCD bus.
    typedef enum logic [1:0] {
        TX_IDLE,
        TX_SETUP,
        TX_PULSE,
        TX_WAIT
    } tx_phase_t;

    // Byte commands issued once the controller has been forced into 4-bit mode.
    localparam logic [7:0] LCD_FUNC_SET = 8'h28;
    localparam logic [7:0] LCD_ENTRY    = 8'h06;
    localparam logic [7:0] LCD_DISP_ON  = 8'h0C;
    localparam logic [7:0] LCD_CLEAR    = 8'h01;

    // Single-nibble wake-up values: 0x3 three times, then 0x2 to enter 4-bit mode.
    localparam logic [3:0] INIT_NIB_WAKE = 4'h3;
    localparam logic [3:0] INIT_NIB_4BIT = 4'h2;

    // Index of the last init byte command (LCD_CLEAR).
    localparam logic [1:0] INIT_CMD_LAST = 2'd3;

    // Clear and return-home (command codes 0x01..0x03) need the long execution wait.
    function automatic logic is_long_wait(input logic rs, input logic [7:0] data);
        return (!rs) && (data[7:2] == 6'd0);
    endfunction

    // Init byte command by position in the init sequence.
    function automatic logic [7:0] init_cmd(input logic [1:0] idx);
        logic [7:0] cmd;
        case (idx)
            2'd0:    cmd = LCD_FUNC_SET;
            2'd1:    cmd = LCD_ENTRY;
            2'd2:    cmd = LCD_DISP_ON;
            default: cmd = LCD_CLEAR;
        endcase
        return cmd;
    endfunction

    // Larger of two unsigned values, used to size the shared wait counter.
    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/lcd_nibble_tx.sv
// Drives one nibble onto the LCD bus: setup with E low, E pulse, then a caller-chosen hold-off.
// A wait-only start skips setup and pulse, which the sequencer uses for the power-on delay.
// done_o is high during the last wait cycle so the caller can chain the next nibble with no gap.
module lcd_nibble_tx
    import lcd_pkg::*;
#(
    parameter int unsigned SETUP_CYC   = 2,
    parameter int unsigned E_PULSE_CYC = 12,
    parameter int unsigned CW          = 20
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start_i,
    input  logic          wait_only_i,
    input  logic          rs_i,
    input  logic [3:0]    nibble_i,
    input  logic [CW-1:0] wait_cnt_i,
    output logic          done_o,
    output logic          lcd_e_o,
    output logic          lcd_rs_o,
    output logic [3:0]    lcd_dat_o
);

    localparam logic [CW-1:0] SETUP_LD = CW'(SETUP_CYC - 1);
    localparam logic [CW-1:0] PULSE_LD = CW'(E_PULSE_CYC - 1);

    tx_phase_t     phase_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] waitLd_q;
    logic          e_q;
    logic          rs_q;
    logic [3:0]    dat_q;

    // Phase sequencer and registered bus lines; a new start always wins, even in the last wait cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q  <= TX_IDLE;
            cnt_q    <= '0;
            waitLd_q <= '0;
            e_q      <= 1'b0;
            rs_q     <= 1'b0;
            dat_q    <= 4'h0;
        end else if (start_i) begin
            rs_q     <= rs_i;
            dat_q    <= nibble_i;
            e_q      <= 1'b0;
            waitLd_q <= wait_cnt_i;
            if (wait_only_i) begin
                phase_q <= TX_WAIT;
                cnt_q   <= wait_cnt_i;
            end else begin
                phase_q <= TX_SETUP;
                cnt_q   <= SETUP_LD;
            end
        end else begin
            case (phase_q)
                TX_SETUP: begin
                    if (cnt_q == '0) begin
                        phase_q <= TX_PULSE;
                        cnt_q   <= PULSE_LD;
                        e_q     <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                TX_PULSE: begin
                    if (cnt_q == '0) begin
                        phase_q <= TX_WAIT;
                        cnt_q   <= waitLd_q;
                        e_q     <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                TX_WAIT: begin
                    if (cnt_q == '0) begin
                        phase_q <= TX_IDLE;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                default: begin
                    phase_q <= TX_IDLE;
                end
            endcase
        end
    end

    assign done_o    = (phase_q == TX_WAIT) && (cnt_q == '0);
    assign lcd_e_o   = e_q;
    assign lcd_rs_o  = rs_q;
    assign lcd_dat_o = dat_q;

endmodule

// File: rtl/lcd_4bit_driver.sv
// HD44780 4-bit bus driver: runs the power-on init sequence, then sends one byte per
// valid/ready handshake as two nibbles, holding off for the controller's execution time.
module lcd_4bit_driver
    import lcd_pkg::*;
#(
    parameter int unsigned SETUP_CYC     = 2,
    parameter int unsigned E_PULSE_CYC   = 12,
    parameter int unsigned NIB_GAP_CYC   = 50,
    parameter int unsigned CMD_WAIT_CYC  = 2000,
    parameter int unsigned LONG_WAIT_CYC = 82000,
    parameter int unsigned POWERON_CYC   = 750000,
    parameter int unsigned INIT1_CYC     = 205000,
    parameter int unsigned INIT2_CYC     = 5000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_valid,
    input  logic       wr_rs,
    input  logic [7:0] wr_data,
    output logic       wr_ready,
    output logic       init_done,
    output logic       lcd_e,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic [3:0] lcd_dat
);

    localparam int unsigned MAX_WAIT = max_u(max_u(max_u(POWERON_CYC, LONG_WAIT_CYC),
                                                   max_u(INIT1_CYC, INIT2_CYC)),
                                             max_u(max_u(CMD_WAIT_CYC, NIB_GAP_CYC),
                                                   max_u(SETUP_CYC, E_PULSE_CYC)));
    localparam int unsigned CW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;

    // The counter runs from N-1 down to 0, so every wait is loaded one short.
    localparam logic [CW-1:0] LD_POWERON = CW'(POWERON_CYC - 1);
    localparam logic [CW-1:0] LD_INIT1   = CW'(INIT1_CYC - 1);
    localparam logic [CW-1:0] LD_INIT2   = CW'(INIT2_CYC - 1);
    localparam logic [CW-1:0] LD_CMD     = CW'(CMD_WAIT_CYC - 1);
    localparam logic [CW-1:0] LD_LONG    = CW'(LONG_WAIT_CYC - 1);
    localparam logic [CW-1:0] LD_GAP     = CW'(NIB_GAP_CYC - 1);

    drv_state_t    state_q;
    drv_state_t    state_d;
    logic [1:0]    initIdx_q;
    logic [1:0]    initIdx_d;
    logic          byteRs_q;
    logic          byteRs_d;
    logic [7:0]    byteData_q;
    logic [7:0]    byteData_d;
    logic          wrReady_q;
    logic          wrReady_d;
    logic          initDone_q;
    logic          initDone_d;

    logic          txStart;
    logic          txWaitOnly;
    logic          txRs;
    logic [3:0]    txNibble;
    logic [CW-1:0] txWait;
    logic          txDone;
    logic [7:0]    nextInitCmd;

    assign nextInitCmd = init_cmd(initIdx_q + 2'd1);

    // Next-state decode; a new nibble is launched on the same edge the previous wait ends.
    always_comb begin
        state_d    = state_q;
        initIdx_d  = initIdx_q;
        byteRs_d   = byteRs_q;
        byteData_d = byteData_q;
        wrReady_d  = wrReady_q;
        initDone_d = initDone_q;
        txStart    = 1'b0;
        txWaitOnly = 1'b0;
        txRs       = 1'b0;
        txNibble   = 4'h0;
        txWait     = LD_CMD;
        case (state_q)
            ST_BOOT: begin
                txStart    = 1'b1;
                txWaitOnly = 1'b1;
                txWait     = LD_POWERON;
                state_d    = ST_POWERON;
            end
            ST_POWERON: begin
                if (txDone) begin
                    txStart  = 1'b1;
                    txNibble = INIT_NIB_WAKE;
                    txWait   = LD_INIT1;
                    state_d  = ST_INIT1;
                end
            end
            ST_INIT1: begin
                if (txDone) begin
                    txStart  = 1'b1;
                    txNibble = INIT_NIB_WAKE;
                    txWait   = LD_INIT2;
                    state_d  = ST_INIT2;
                end
            end
            ST_INIT2: begin
                if (txDone) begin
                    txStart  = 1'b1;
                    txNibble = INIT_NIB_WAKE;
                    txWait   = LD_CMD;
                    state_d  = ST_INIT3;
                end
            end
            ST_INIT3: begin
                if (txDone) begin
                    txStart  = 1'b1;
                    txNibble = INIT_NIB_4BIT;
                    txWait   = LD_CMD;
                    state_d  = ST_INIT4;
                end
            end
            ST_INIT4: begin
                if (txDone) begin
                    initIdx_d  = 2'd0;
                    byteRs_d   = 1'b0;
                    byteData_d = LCD_FUNC_SET;
                    txStart    = 1'b1;
                    txNibble   = LCD_FUNC_SET[7:4];
                    txWait     = LD_GAP;
                    state_d    = ST_HI;
                end
            end
            ST_HI: begin
                if (txDone) begin
                    txStart  = 1'b1;
                    txRs     = byteRs_q;
                    txNibble = byteData_q[3:0];
                    txWait   = is_long_wait(byteRs_q, byteData_q) ? LD_LONG : LD_CMD;
                    state_d  = ST_LO;
                end
            end
            ST_LO: begin
                if (txDone) begin
                    if (!initDone_q && (initIdx_q != INIT_CMD_LAST)) begin
                        initIdx_d  = initIdx_q + 2'd1;
                        byteData_d = nextInitCmd;
                        txStart    = 1'b1;
                        txNibble   = nextInitCmd[7:4];
                        txWait     = LD_GAP;
                        state_d    = ST_HI;
                    end else begin
                        initDone_d = 1'b1;
                        wrReady_d  = 1'b1;
                        state_d    = ST_IDLE;
                    end
                end
            end
            ST_IDLE: begin
                if (wr_valid && wrReady_q) begin
                    byteRs_d   = wr_rs;
                    byteData_d = wr_data;
                    wrReady_d  = 1'b0;
                    txStart    = 1'b1;
                    txRs       = wr_rs;
                    txNibble   = wr_data[7:4];
                    txWait     = LD_GAP;
                    state_d    = ST_HI;
                end
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase
    end

    // Sequencer state, latched byte and the registered handshake outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_BOOT;
            initIdx_q  <= 2'd0;
            byteRs_q   <= 1'b0;
            byteData_q <= 8'h00;
            wrReady_q  <= 1'b0;
            initDone_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            initIdx_q  <= initIdx_d;
            byteRs_q   <= byteRs_d;
            byteData_q <= byteData_d;
            wrReady_q  <= wrReady_d;
            initDone_q <= initDone_d;
        end
    end

    lcd_nibble_tx #(
        .SETUP_CYC   (SETUP_CYC),
        .E_PULSE_CYC (E_PULSE_CYC),
        .CW          (CW)
    ) u_nibble_tx (
        .clk         (clk),
        .rst         (rst),
        .start_i     (txStart),
        .wait_only_i (txWaitOnly),
        .rs_i        (txRs),
        .nibble_i    (txNibble),
        .wait_cnt_i  (txWait),
        .done_o      (txDone),
        .lcd_e_o     (lcd_e),
        .lcd_rs_o    (lcd_rs),
        .lcd_dat_o   (lcd_dat)
    );

    assign wr_ready  = wrReady_q;
    assign init_done = initDone_q;
    assign lcd_rw    = 1'b0;

endmodule

// File: tb/tb_lcd_4bit_driver.sv
// Testbench for lcd_4bit_driver with shortened timing parameters.
module tb_lcd_4bit_driver;

    localparam int TB_SETUP   = 2;
    localparam int TB_EPULSE  = 4;
    localparam int TB_GAP     = 5;
    localparam int TB_CMD     = 20;
    localparam int TB_LONG    = 60;
    localparam int TB_POWERON = 100;
    localparam int TB_INIT1   = 40;
    localparam int TB_INIT2   = 10;

    typedef struct {
        logic       rs;
        logic [3:0] nib;
        int         width;
    } pulse_t;

    typedef struct {
        bit rs;
        int data;
        int expLat;
    } vec_t;

    logic       clk;
    logic       rst;
    logic       wr_valid;
    logic       wr_rs;
    logic [7:0] wr_data;
    logic       wr_ready;
    logic       init_done;
    logic       lcd_e;
    logic       lcd_rs;
    logic       lcd_rw;
    logic [3:0] lcd_dat;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int lastFallCyc = 0;
    int rwErr = 0;
    int stableErr = 0;

    pulse_t seenQ[$];
    pulse_t expQ[$];

    logic       ePrev = 1'b0;
    logic       curRs = 1'b0;
    logic [3:0] curNib = 4'h0;
    int         curW = 0;
    logic       prevRs = 1'b0;
    logic       prev2Rs = 1'b0;
    logic [3:0] prevDat = 4'h0;
    logic [3:0] prev2Dat = 4'h0;

    int initNibbles[4] = '{3, 3, 3, 2};
    vec_t vecs[8];

    lcd_4bit_driver #(
        .SETUP_CYC     (TB_SETUP),
        .E_PULSE_CYC   (TB_EPULSE),
        .NIB_GAP_CYC   (TB_GAP),
        .CMD_WAIT_CYC  (TB_CMD),
        .LONG_WAIT_CYC (TB_LONG),
        .POWERON_CYC   (TB_POWERON),
        .INIT1_CYC     (TB_INIT1),
        .INIT2_CYC     (TB_INIT2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_valid  (wr_valid),
        .wr_rs     (wr_rs),
        .wr_data   (wr_data),
        .wr_ready  (wr_ready),
        .init_done (init_done),
        .lcd_e     (lcd_e),
        .lcd_rs    (lcd_rs),
        .lcd_rw    (lcd_rw),
        .lcd_dat   (lcd_dat)
    );

    // 100 MHz-style bench clock; only cycle counts matter here.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Free-running cycle index used to time E edges against init_done.
    always @(posedge clk) cyc <= cyc + 1;

    // Bus monitor: records every completed E pulse with its rs, nibble and width in cycles.
    always @(negedge clk) begin
        if (rst) begin
            ePrev <= 1'b0;
            prevRs <= 1'b0;
            prev2Rs <= 1'b0;
            prevDat <= 4'h0;
            prev2Dat <= 4'h0;
        end else begin
            if (lcd_rw !== 1'b0) rwErr <= rwErr + 1;
            if (lcd_e && !ePrev) begin
                curRs <= lcd_rs;
                curNib <= lcd_dat;
                curW <= 1;
                if (lcd_rs !== prevRs || lcd_dat !== prevDat ||
                    lcd_rs !== prev2Rs || lcd_dat !== prev2Dat) stableErr <= stableErr + 1;
            end else if (lcd_e) begin
                curW <= curW + 1;
                if (lcd_rs !== curRs || lcd_dat !== curNib) stableErr <= stableErr + 1;
            end else if (ePrev) begin
                seenQ.push_back('{curRs, curNib, curW});
                lastFallCyc <= cyc;
                if (lcd_rs !== curRs || lcd_dat !== curNib) stableErr <= stableErr + 1;
            end
            ePrev <= lcd_e;
            prevRs <= lcd_rs;
            prev2Rs <= prevRs;
            prevDat <= lcd_dat;
            prev2Dat <= prevDat;
        end
    end

    // Hard stop in case something wedges outside the bounded waits.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkVal(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic checkRange(input string name, input int actual, input int lo, input int hi);
        checks++;
        if (actual < lo || actual > hi) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d..%0d", name, actual, lo, hi);
        end
    endtask

    // Reference model: post-byte latency from the handshake rule.
    function automatic int expLatency(input bit rs, input int data);
        return 2 * TB_SETUP + 2 * TB_EPULSE + TB_GAP + ((!rs && data < 4) ? TB_LONG : TB_CMD);
    endfunction

    task automatic pushNibble(input bit rs, input int nib);
        pulse_t p;
        p.rs = rs;
        p.nib = 4'(nib);
        p.width = TB_EPULSE;
        expQ.push_back(p);
    endtask

    task automatic pushByte(input bit rs, input int data);
        pushNibble(rs, data / 16);
        pushNibble(rs, data % 16);
    endtask

    task automatic checkOutput(input string tag);
        pulse_t e;
        pulse_t s;
        int idx = 0;
        while (expQ.size() > 0) begin
            e = expQ.pop_front();
            if (seenQ.size() == 0) begin
                checkVal($sformatf("%s pulse %0d present", tag, idx), 0, 1);
            end else begin
                s = seenQ.pop_front();
                checkVal($sformatf("%s pulse %0d rs", tag, idx), s.rs, e.rs);
                checkVal($sformatf("%s pulse %0d nibble", tag, idx), s.nib, e.nib);
                checkVal($sformatf("%s pulse %0d width", tag, idx), s.width, e.width);
            end
            idx++;
        end
        checkVal({tag, " extra pulses"}, seenQ.size(), 0);
        seenQ.delete();
    endtask

    task automatic checkOutputsZero(input string tag);
        checkVal({tag, " lcd_e"}, lcd_e, 0);
        checkVal({tag, " lcd_rs"}, lcd_rs, 0);
        checkVal({tag, " lcd_rw"}, lcd_rw, 0);
        checkVal({tag, " lcd_dat"}, lcd_dat, 0);
        checkVal({tag, " wr_ready"}, wr_ready, 0);
        checkVal({tag, " init_done"}, init_done, 0);
    endtask

    // Releases reset and checks the power-on wait and the complete init pulse train.
    task automatic runInit(input string tag);
        int n;
        bit seen;
        int pairErr;
        for (int i = 0; i < 4; i++) pushNibble(1'b0, initNibbles[i]);
        pushByte(1'b0, 'h28);
        pushByte(1'b0, 'h06);
        pushByte(1'b0, 'h0C);
        pushByte(1'b0, 'h01);
        @(negedge clk);
        rst = 1'b0;
        n = 0;
        seen = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            n++;
            if (lcd_e) begin
                seen = 1'b1;
                break;
            end
        end
        checkRange({tag, " power-on wait"}, seen ? n : 0, TB_POWERON + 1, TB_POWERON + TB_SETUP + 10);
        seen = 1'b0;
        pairErr = 0;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            if (wr_ready !== init_done) pairErr++;
            if (init_done) begin
                seen = 1'b1;
                break;
            end
        end
        checkVal({tag, " init_done reached"}, seen, 1);
        checkVal({tag, " ready tracks init_done"}, pairErr, 0);
        checkVal({tag, " final wait"}, cyc - lastFallCyc, TB_LONG);
        checkOutput({tag, " init"});
    endtask

    // Called right at the accepting edge; measures ready latency and checks the nibbles sent.
    task automatic finishTransfer(input string tag, input bit rs, input int data, input int expLat);
        int n;
        bit seen;
        #1;
        wr_valid = 1'b0;
        checkVal({tag, " ready drops"}, wr_ready, 0);
        n = 0;
        seen = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(posedge clk);
            #1;
            n++;
            if (wr_ready) begin
                seen = 1'b1;
                break;
            end
            if (n == 5) begin
                wr_valid = 1'b1;
                wr_rs = ~rs;
                wr_data = 8'(~data);
            end
            if (n == 9) wr_valid = 1'b0;
        end
        wr_valid = 1'b0;
        checkVal({tag, " ready latency"}, seen ? n : -1, expLat);
        checkVal({tag, " init_done held"}, init_done, 1);
        pushByte(rs, data);
        checkOutput(tag);
    endtask

    task automatic waitReady(input string tag, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (wr_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) checkVal({tag, " ready before write"}, 0, 1);
    endtask

    task automatic applyStimulus(input string tag, input bit rs, input int data, input int expLat);
        bit ok;
        waitReady(tag, ok);
        if (ok) begin
            wr_rs = rs;
            wr_data = 8'(data);
            wr_valid = 1'b1;
            @(posedge clk);
            finishTransfer(tag, rs, data, expLat);
        end
    endtask

    initial begin
        bit ok;
        bit seen;
        int n;
        bit rrs;
        int rdata;

        vecs[0] = '{1'b1, 'h41, 37};
        vecs[1] = '{1'b0, 'h01, 77};
        vecs[2] = '{1'b0, 'h02, 77};
        vecs[3] = '{1'b1, 'h01, 37};
        vecs[4] = '{1'b0, 'h03, 77};
        vecs[5] = '{1'b0, 'h04, 37};
        vecs[6] = '{1'b1, 'h00, 37};
        vecs[7] = '{1'b0, 'h80, 37};

        rst = 1'b0;
        wr_valid = 1'b0;
        wr_rs = 1'b0;
        wr_data = 8'h00;
        #2;
        rst = 1'b1;
        #1;
        checkOutputsZero("reset");

        // Request held from reset: must be ignored until init completes, then sent once.
        wr_valid = 1'b1;
        wr_rs = 1'b1;
        wr_data = 8'h55;
        repeat (3) @(negedge clk);
        checkOutputsZero("reset held");
        runInit("power-up");
        @(posedge clk);
        finishTransfer("held valid", 1'b1, 'h55, expLatency(1'b1, 'h55));

        for (int i = 0; i < 8; i++) begin
            applyStimulus($sformatf("vec %0d", i), vecs[i].rs, vecs[i].data, vecs[i].expLat);
        end

        for (int i = 0; i < 12; i++) begin
            rrs = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) rdata = int'($urandom_range(0, 5));
            else rdata = int'($urandom_range(0, 255));
            applyStimulus($sformatf("rand %0d", i), rrs, rdata, expLatency(rrs, rdata));
        end

        // Back-to-back with wr_valid held: second byte goes on the first ready cycle.
        waitReady("b2b", ok);
        if (ok) begin
            wr_valid = 1'b1;
            wr_rs = 1'b1;
            wr_data = 8'h48;
            @(posedge clk);
            #1;
            wr_data = 8'h49;
            checkVal("b2b ready drops", wr_ready, 0);
            n = 0;
            seen = 1'b0;
            for (int i = 0; i < 1000; i++) begin
                @(posedge clk);
                #1;
                n++;
                if (wr_ready) begin
                    seen = 1'b1;
                    break;
                end
            end
            checkVal("b2b first latency", seen ? n : -1, expLatency(1'b1, 'h48));
            @(posedge clk);
            #1;
            checkVal("b2b second accepted", wr_ready, 0);
            wr_valid = 1'b0;
            n = 0;
            seen = 1'b0;
            for (int i = 0; i < 1000; i++) begin
                @(posedge clk);
                #1;
                n++;
                if (wr_ready) begin
                    seen = 1'b1;
                    break;
                end
            end
            checkVal("b2b second latency", seen ? n : -1, expLatency(1'b1, 'h49));
            pushByte(1'b1, 'h48);
            pushByte(1'b1, 'h49);
            checkOutput("b2b");
        end

        // Reset in the middle of the upper-nibble E pulse, then a full re-init.
        waitReady("mid reset", ok);
        if (ok) begin
            wr_rs = 1'b1;
            wr_data = 8'h41;
            wr_valid = 1'b1;
            @(posedge clk);
            #1;
            wr_valid = 1'b0;
            seen = 1'b0;
            for (int i = 0; i < 50; i++) begin
                @(negedge clk);
                if (lcd_e) begin
                    seen = 1'b1;
                    break;
                end
            end
            checkVal("mid reset E seen", seen, 1);
            #2;
            rst = 1'b1;
            #1;
            checkOutputsZero("mid reset async");
            repeat (3) @(negedge clk);
            expQ.delete();
            seenQ.delete();
            runInit("re-init");
            applyStimulus("post re-init", 1'b0, 'h0C, 37);
        end

        checkVal("lcd_rw never high", rwErr, 0);
        checkVal("rs/dat stable around E", stableErr, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
